jtag_scan_engine: RTL and testbench

JTAG_SCAN_ENGINE -- requirements
Module: jtag_scan_engine

---
 rtl/jtag_scan_if.sv | 32 +++
 rtl/jtag_scan_engine.sv | 186 ++++++++++++++++++
 tb/tb_jtag_scan_engine.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_scan_if.sv
// jtag_scan_if: command handshake, JTAG pins and TX/RX FIFO ports of jtag_scan_engine.
// The engine uses the slave modport; the command source and FIFOs use master.
interface jtag_scan_if #(
    parameter int WORD = 8
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [15:0]     cmd_len;
    logic            busy;
    logic            done;
    logic            tck;
    logic            tms;
    logic            tdi;
    logic            tdo;
    logic [WORD-1:0] tx_rdata;
    logic            tx_rd;
    logic            tx_empty;
    logic [WORD-1:0] rx_wdata;
    logic            rx_wr;
    logic            rx_full;

    modport master (
        output cmd_valid, cmd_op, cmd_len, tdo, tx_rdata, tx_empty, rx_full,
        input  cmd_ready, busy, done, tck, tms, tdi, tx_rd, rx_wdata, rx_wr
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, tdo, tx_rdata, tx_empty, rx_full,
        output cmd_ready, busy, done, tck, tms, tdi, tx_rd, rx_wdata, rx_wr
    );
endinterface

// File: rtl/jtag_scan_engine.sv
// jtag_scan_engine: JTAG scan engine running IR/DR shifts, TAP reset and idle clocks from TX/RX FIFOs.
// TDO capture into the RX FIFO exists only when JTAG_SCAN_CAPTURE_EN is defined.
module jtag_scan_engine #(
    parameter int WORD       = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CLK_DIV    = 2,
    parameter int IDLE_AFTER = 1
) (
    input logic        clk,
    input logic        rst,
    jtag_scan_if.slave bus
);
`ifdef JTAG_SCAN_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif
    localparam int BW = (WORD > 1 && FIFO_DEPTH >= 0) ? $clog2(WORD) : 1;

    typedef enum logic [2:0] {IDLE, NAV, LOAD, SHIFT, STALL, EXIT, DONE} state_t;

    state_t          r_state;
    logic [1:0]      r_op;
    logic [15:0]     r_cnt;
    logic [15:0]     r_div;
    logic [5:0]      r_nav;
    logic [2:0]      r_nav_n;
    logic [BW-1:0]   r_bit;
    logic [WORD-1:0] r_tx;
    logic [WORD-1:0] r_rx;
    logic [WORD-1:0] r_rx_wdata;
    logic            r_first;
    logic            r_ready;
    logic            r_busy;
    logic            r_done;
    logic            r_tck;
    logic            r_tms;
    logic            r_tdi;
    logic            r_tx_rd;
    logic            r_rx_wr;

    logic            w_run, w_tick, w_rise, w_end, w_final, w_wend, w_nav_last;
    logic            w_pop, w_push, w_hold, w_adv, w_accept;
    logic [15:0]     w_ncnt;
    logic [WORD-1:0] w_src;
    logic [5:0]      w_seq;
    logic [2:0]      w_seq_n;

    assign w_run      = r_state == NAV || r_state == SHIFT || r_state == EXIT;
    assign w_tick     = r_div == 16'(CLK_DIV - 1);
    assign w_rise     = !r_tck && w_tick;
    assign w_end      = r_tck && w_tick;
    assign w_final    = r_cnt == 16'd1;
    assign w_wend     = r_bit == BW'(WORD - 1);
    assign w_nav_last = (r_op == 2'b11) ? w_final : r_nav_n == 3'd1;
    // r_first marks the LOAD pop; afterwards pops/pushes fall on word boundaries and the final bit
    assign w_pop      = r_first || (!w_final && w_wend);
    assign w_push     = CAP && !r_first && (w_final || w_wend);
    assign w_hold     = (w_pop && bus.tx_empty) || (w_push && bus.rx_full);
    assign w_adv      = !w_hold && (r_state == LOAD || r_state == STALL || (r_state == SHIFT && w_end));
    assign w_ncnt     = r_first ? r_cnt : r_cnt - 16'd1;
    assign w_src      = w_pop ? bus.tx_rdata : r_tx;
    assign w_accept   = r_state == IDLE && r_ready && bus.cmd_valid;
    // TMS walks from Run-Test/Idle, LSB first: Shift-IR, Shift-DR, Test-Logic-Reset then Idle
    assign w_seq      = bus.cmd_op == 2'b00 ? 6'b000011 : bus.cmd_op == 2'b01 ? 6'b000001 :
                        bus.cmd_op == 2'b10 ? 6'b011111 : 6'b000000;
    assign w_seq_n    = bus.cmd_op == 2'b00 ? 3'd4 : bus.cmd_op == 2'b01 ? 3'd3 : 3'd6;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_op       <= '0;
            r_cnt      <= '0;
            r_div      <= '0;
            r_nav      <= '0;
            r_nav_n    <= '0;
            r_bit      <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_rx_wdata <= '0;
            r_first    <= 1'b0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_tck      <= 1'b0;
            r_tms      <= 1'b0;
            r_tdi      <= 1'b0;
            r_tx_rd    <= 1'b0;
            r_rx_wr    <= 1'b0;
        end else begin
            r_tx_rd <= 1'b0;
            r_rx_wr <= 1'b0;
            r_done  <= 1'b0;
            if (w_run) begin
                r_div <= w_tick ? 16'd0 : r_div + 16'd1;
                if (w_tick) r_tck <= !r_tck;
                if (w_rise && r_state == SHIFT) r_rx[r_bit] <= bus.tdo;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_op    <= bus.cmd_op;
                        r_cnt   <= bus.cmd_len;
                        r_div   <= '0;
                        r_nav   <= w_seq >> 1;
                        r_nav_n <= w_seq_n;
                        r_first <= 1'b1;
                        r_bit   <= '0;
                        r_rx    <= '0;
                        if (bus.cmd_op != 2'b10 && bus.cmd_len == 16'd0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= NAV;
                            r_tms   <= w_seq[0];
                        end
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                NAV: begin
                    if (w_end && w_nav_last) begin
                        r_state <= r_op[1] ? DONE : LOAD;
                        r_done  <= r_op[1];
                    end else if (w_end) begin
                        r_tms   <= r_nav[0];
                        r_nav   <= r_nav >> 1;
                        r_nav_n <= r_nav_n - 3'd1;
                        r_cnt   <= (r_op == 2'b11) ? r_cnt - 16'd1 : r_cnt;
                    end
                end
                LOAD, SHIFT, STALL: if (w_hold && (r_state != SHIFT || w_end)) r_state <= STALL;
                EXIT: begin
                    if (w_end && r_nav_n == 3'd1) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else if (w_end) begin
                        r_tms   <= 1'b0;
                        r_nav_n <= r_nav_n - 3'd1;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            if (w_adv) begin
                r_tx_rd <= w_pop;
                r_rx_wr <= w_push;
                if (w_push) begin
                    r_rx_wdata <= r_rx;
                    r_rx       <= '0;
                end
                r_first <= 1'b0;
                r_div   <= '0;
                r_tck   <= 1'b0;
                if (w_final && !r_first) begin
                    r_state <= EXIT;
                    r_tms   <= 1'b1;
                    r_nav_n <= (IDLE_AFTER != 0) ? 3'd2 : 3'd1;
                end else begin
                    r_state <= SHIFT;
                    r_cnt   <= w_ncnt;
                    r_tms   <= w_ncnt == 16'd1;
                    r_tdi   <= w_src[0];
                    r_tx    <= w_src >> 1;
                    r_bit   <= (r_first || w_wend) ? BW'(0) : r_bit + BW'(1);
                end
            end
        end
    end

    assign bus.cmd_ready = r_ready;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.tck       = r_tck;
    assign bus.tms       = r_tms;
    assign bus.tdi       = r_tdi;
    assign bus.tx_rd     = r_tx_rd;
    assign bus.rx_wdata  = r_rx_wdata;
    assign bus.rx_wr     = r_rx_wr;
endmodule

// File: tb/tb_jtag_scan_engine.sv
// tb_jtag_scan_engine: directed checks of jtag_scan_engine with WORD=8, CLK_DIV=2, IDLE_AFTER=1.
// TDO is looped back to TDI; TX/RX FIFOs are small models updated on the falling clock edge.
module tb_jtag_scan_engine;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic hold_empty = 1'b0;
    int checks = 0;
    int errors = 0;
    int n_tck = 0;
    int n_done = 0;
    int tx_rp = 0;
    int tx_wp = 0;
    int rx_wp = 0;
    int base, tx0, rx0, d0, hi;
    logic [7:0] tx_mem [0:15];
    logic [7:0] rx_mem [0:15];
    logic tms_a [0:255];
    logic tdi_a [0:255];

    jtag_scan_if #(.WORD(8)) bus ();

    jtag_scan_engine #(.WORD(8), .FIFO_DEPTH(16), .CLK_DIV(2), .IDLE_AFTER(1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    assign bus.tdo = bus.tdi;

    always @(posedge bus.tck) begin
        tms_a[n_tck % 256] = bus.tms;
        tdi_a[n_tck % 256] = bus.tdi;
        n_tck++;
    end

    always @(negedge clk) begin
        if (bus.tx_rd) tx_rp++;
        if (bus.rx_wr) begin
            rx_mem[rx_wp % 16] = bus.rx_wdata;
            rx_wp++;
        end
        if (bus.done) n_done++;
        bus.tx_rdata = tx_mem[tx_rp % 16];
        bus.tx_empty = hold_empty || tx_rp == tx_wp;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] vec(input int from, input int n, input bit want_tdi);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = want_tdi ? tdi_a[(from + i) % 256] : tms_a[(from + i) % 256];
        return v;
    endfunction

    task automatic push_tx(input logic [7:0] d);
        tx_mem[tx_wp % 16] = d;
        tx_wp++;
    endtask

    task automatic issue(input logic [1:0] op, input logic [15:0] len);
        int i;
        i = 0;
        @(negedge clk);
        while (!bus.cmd_ready && i < 20) begin
            @(negedge clk);
            i++;
        end
        check("cmd_ready_before_issue", bus.cmd_ready, 1);
        base = n_tck;
        tx0 = tx_rp;
        rx0 = rx_wp;
        d0 = n_done;
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op;
        bus.cmd_len = len;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = ~op;
        bus.cmd_len = 16'hFFFF;
    endtask

    task automatic wait_done();
        int i;
        i = 0;
        while (n_done == d0 && i < 2000) begin
            @(negedge clk);
            i++;
        end
        check("done_seen", 64'(n_done != d0), 1);
        @(negedge clk);
        check("busy_after_done", bus.busy, 0);
        check("done_width", n_done - d0, 1);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 2'b00;
        bus.cmd_len = 16'd0;
        bus.rx_full = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tck", bus.tck, 0);
        check("rst_tms", bus.tms, 0);
        check("rst_tdi", bus.tdi, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ready", bus.cmd_ready, 0);
        check("rst_done", bus.done, 0);
        check("rst_tx_rd", bus.tx_rd, 0);
        check("rst_rx_wr", bus.rx_wr, 0);
        check("rst_rx_wdata", bus.rx_wdata, 0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", bus.cmd_ready, 1);

        // IR shift of 10 bits across two TX words
        push_tx(8'hA5);
        push_tx(8'h03);
        issue(2'b00, 16'd10);
        wait_done();
        check("ir_tck_count", n_tck - base, 16);
        check("ir_tms", vec(base, 16, 0), 64'h6003);
        check("ir_tdi", vec(base + 4, 10, 1), 64'h3A5);
        check("ir_pops", tx_rp - tx0, 2);
`ifdef JTAG_SCAN_CAPTURE_EN
        check("ir_rx_pushes", rx_wp - rx0, 2);
        check("ir_rx_word0", rx_mem[rx0 % 16], 8'hA5);
        check("ir_rx_word1", rx_mem[(rx0 + 1) % 16], 8'h03);
`else
        check("ir_rx_pushes", rx_wp - rx0, 0);
        check("ir_rx_wdata", bus.rx_wdata, 0);
`endif

        // DR shift stalled at LOAD by an empty TX FIFO
        hold_empty = 1'b1;
        push_tx(8'h3C);
        issue(2'b01, 16'd8);
        repeat (20) @(negedge clk);
        hi = 0;
        repeat (20) begin
            @(negedge clk);
            hi += int'(bus.tck);
        end
        check("load_stall_tck_high", hi, 0);
        check("load_stall_tck_count", n_tck - base, 3);
        check("load_stall_pops", tx_rp - tx0, 0);
        check("load_stall_busy", bus.busy, 1);
        hold_empty = 1'b0;
        wait_done();
        check("dr8_tck_count", n_tck - base, 13);
        check("dr8_tms", vec(base, 13, 0), 64'h0C01);
        check("dr8_tdi", vec(base + 3, 8, 1), 64'h3C);
        check("dr8_pops", tx_rp - tx0, 1);

        // DR shift of 12 bits stalling on the second pop
        push_tx(8'h5A);
        issue(2'b01, 16'd12);
        repeat (80) @(negedge clk);
        check("mid_stall_tck_count", n_tck - base, 11);
        check("mid_stall_tck", bus.tck, 0);
        check("mid_stall_pops", tx_rp - tx0, 1);
        check("mid_stall_busy", bus.busy, 1);
        push_tx(8'h0F);
        wait_done();
        check("dr12_tck_count", n_tck - base, 17);
        check("dr12_tms", vec(base, 17, 0), 64'hC001);
        check("dr12_tdi", vec(base + 3, 12, 1), 64'hF5A);
        check("dr12_pops", tx_rp - tx0, 2);

        // TAP reset
        issue(2'b10, 16'd0);
        wait_done();
        check("rst_op_tck_count", n_tck - base, 6);
        check("rst_op_tms", vec(base, 6, 0), 64'h1F);
        check("rst_op_pops", tx_rp - tx0, 0);
        check("rst_op_pushes", rx_wp - rx0, 0);

        // idle clocks
        issue(2'b11, 16'd5);
        wait_done();
        check("idle5_tck_count", n_tck - base, 5);
        check("idle5_tms", vec(base, 5, 0), 64'h0);
        check("idle5_pops", tx_rp - tx0, 0);

        // zero-length idle clocks: done in the cycle after acceptance
        issue(2'b11, 16'd0);
        @(negedge clk);
        check("len0_done", bus.done, 1);
        check("len0_ready", bus.cmd_ready, 0);
        @(negedge clk);
        check("len0_done_clear", bus.done, 0);
        check("len0_ready_back", bus.cmd_ready, 1);
        check("len0_tck_count", n_tck - base, 0);

`ifdef JTAG_SCAN_CAPTURE_EN
        // final partial word held back by a full RX FIFO
        bus.rx_full = 1'b1;
        push_tx(8'h15);
        issue(2'b01, 16'd5);
        repeat (60) @(negedge clk);
        check("rx_stall_pushes", rx_wp - rx0, 0);
        check("rx_stall_tck", bus.tck, 0);
        check("rx_stall_busy", bus.busy, 1);
        bus.rx_full = 1'b0;
        wait_done();
        check("rx5_pushes", rx_wp - rx0, 1);
        check("rx5_word", rx_mem[rx0 % 16], 8'h15);
`endif

        // reset during bit 4 of a DR shift, then a clean TAP reset
        push_tx(8'hFF);
        issue(2'b01, 16'd8);
        hi = 0;
        while (n_tck - base < 8 && hi < 200) begin
            @(negedge clk);
            hi++;
        end
        check("midrst_reached_bit4", n_tck - base, 8);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_tck", bus.tck, 0);
        check("midrst_tms", bus.tms, 0);
        check("midrst_tdi", bus.tdi, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_ready", bus.cmd_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready_after", bus.cmd_ready, 1);
        issue(2'b10, 16'd3);
        wait_done();
        check("post_rst_tck_count", n_tck - base, 6);
        check("post_rst_tms", vec(base, 6, 0), 64'h1F);
        check("post_rst_pops", tx_rp - tx0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
